mem_access_controller: RTL
==========================

MEM_ACCESS_CONTROLLER -- requirements
Module: mem_access_controller

Interface
REQ-001 Parameter SP_RESET, default 32'h0000_07FF: stack pointer reset value (top word of the 2^11-word data memory).
REQ-002 Parameter STACK_LIMIT, default 32'h0000_0400: lowest word address the stack may occupy.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  memory-stage request present.
REQ-006 req_op  in  3  000 NOP, 001 LOAD, 010 STORE, 011 PUSH, 100 POP, 101 PUSH32, 110 POP32, 111 reserved.
REQ-007 req_addr  in  32  LOAD/STORE word address.
REQ-008 req_wdata  in  32  STORE/PUSH data in [15:0]; PUSH32 data in [31:0].
REQ-009 stall  out  1  hold memory stage and everything upstream.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  32  LOAD/POP data zero-extended; POP32 full word.
REQ-012 err  out  1  stack overflow/underflow flag, valid with rsp_valid.
REQ-013 sp  out  32  current stack pointer.
REQ-014 mem_address  out  32  to data memory address.
REQ-015 mem_write_data  out  16  to data memory writeData.
REQ-016 mem_read_data  in  16  from data memory readData (combinational read).
REQ-017 mem_read, mem_write, mem_cs, mem_push  out  1 each  data memory strobes.

Function
REQ-018 FSM states IDLE, ACC1, ACC2; requests are accepted only in IDLE.
REQ-019 Accept when state==IDLE and req_valid==1; op, address, data are captured; op 000/111 completes as NOP.
REQ-020 stall = (state!=IDLE) | (state==IDLE & req_valid & req_op not in {000,111}), combinational.
REQ-021 Transitions: IDLE->ACC1 on accepted non-NOP; ACC1->ACC2 for PUSH32/POP32; ACC1->IDLE for 16-bit ops; ACC2->IDLE.
REQ-022 All mem_* outputs are registered, valid only during ACC1/ACC2; mem_read/mem_write/mem_cs are 0 in IDLE.
REQ-023 Every memory access is one cycle; mem_write asserts for exactly one cycle per written word and mem_push toggles on every written word.
REQ-024 mem_read and mem_write are never asserted in the same cycle.
REQ-025 Read data is sampled from mem_read_data at the end of the access cycle.
REQ-026 LOAD: mem_address=req_addr, read; STORE: mem_address=req_addr, write req_wdata[15:0].
REQ-027 PUSH: write req_wdata[15:0] at SP; SP <= SP-1.
REQ-028 POP: read SP+1; SP <= SP+1.
REQ-029 PUSH32: ACC1 writes [31:16] at SP, ACC2 writes [15:0] at SP-1; SP <= SP-2.
REQ-030 POP32: ACC1 reads SP+1 into rsp_rdata[15:0], ACC2 reads SP+2 into [31:16]; SP <= SP+2.
REQ-031 SP update is committed at the end of the last access cycle; all SP arithmetic is 32-bit modulo.
REQ-032 Overflow: PUSH with SP<STACK_LIMIT, or PUSH32 with SP<STACK_LIMIT+1, performs no write, leaves SP unchanged, and sets err=1.
REQ-033 Underflow: POP with SP>=SP_RESET, or POP32 with SP>SP_RESET-2, performs no read, leaves SP unchanged, returns rsp_rdata=0, and sets err=1.
REQ-034 Faulted ops keep normal latency and FSM path, with mem_cs=0 in their access cycles.
REQ-035 Latency: rsp_valid pulses at T+2 for 16-bit ops, T+3 for 32-bit ops, and T+1 for NOP (T = accept cycle).
REQ-036 In the rsp_valid cycle the state is IDLE, stall follows REQ-020, and a back-to-back request is accepted.
REQ-037 rsp_rdata and err hold their value until the next rsp_valid; err=0 for non-faulting ops.
REQ-038 req_valid/req_op changes while state!=IDLE are ignored.

Reset
REQ-039 rst=1 forces immediately: state=IDLE, SP=SP_RESET, rsp_valid=0, rsp_rdata=0, err=0, mem_read=mem_write=mem_cs=mem_push=0, mem_address=0, mem_write_data=0.
REQ-040 Reset during ACC1/ACC2 aborts the access; a PUSH32 interrupted after ACC1 leaves one written word and SP=SP_RESET; no rsp_valid is produced.

Verification
REQ-041 After reset, PUSH 16'hABCD -> one write at 0x7FF, sp=0x7FE, rsp_valid at T+2, err=0; then POP -> read 0x7FF, rsp_rdata=0x0000ABCD, sp=0x7FF.
REQ-042 PUSH32 0x1234_5678 then POP32 -> writes 0x1234@0x7FF, 0x5678@0x7FE, mem_push toggles twice; POP32 returns 0x12345678; sp returns to 0x7FF; stall high 3 cycles each.
REQ-043 POP from reset SP -> err=1, rsp_rdata=0, sp=0x7FF, mem_cs never asserted.
REQ-044 Push until sp=0x3FF, then PUSH -> err=1, no mem_write, sp stays 0x3FF.
REQ-045 STORE 0x55AA@0x10 immediately followed by LOAD 0x10 (back-to-back) -> LOAD accepted in the STORE's rsp_valid cycle and returns 0x000055AA.
REQ-046 rst asserted during ACC2 of PUSH32 -> all strobes 0 the same cycle, sp=0x7FF, no rsp_valid, and the next request is accepted normally.

Source files
------------

// File: rtl/mem_access_controller_if.sv
// ============================================================================
// Module      : mem_access_controller_if
// Description : Request/response and data-memory bus of mem_access_controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface mem_access_controller_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err;
    logic [31:0] sp;
    logic [31:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_cs;
    logic        mem_push;

    // Requester side; it also models the data memory's read port.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_read_data,
        input  stall, rsp_valid, rsp_rdata, err, sp,
        input  mem_address, mem_write_data, mem_read, mem_write, mem_cs, mem_push
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_read_data,
        output stall, rsp_valid, rsp_rdata, err, sp,
        output mem_address, mem_write_data, mem_read, mem_write, mem_cs, mem_push
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_controller.sv
// ============================================================================
// Module      : mem_access_controller
// Description : Memory-stage controller for LOAD/STORE and 16/32-bit stack ops.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_access_controller #(
    parameter logic [31:0] SP_RESET    = 32'h0000_07FF,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_0400
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mem_access_controller_if.slave  bus_if
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_PUSH   = 3'b011;
    localparam logic [2:0] OP_POP    = 3'b100;
    localparam logic [2:0] OP_PUSH32 = 3'b101;
    localparam logic [2:0] OP_POP32  = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC1 = 2'd1,
        S_ACC2 = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  op_q,        op_d;
    logic        fault_q,     fault_d;
    logic [15:0] wlo_q,       wlo_d;
    logic [15:0] rlo_q,       rlo_d;
    logic [31:0] sp_q,        sp_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q,  mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_cs_q,    mem_cs_d;
    logic        mem_push_q,  mem_push_d;

    logic        w_req_nop;
    logic        w_req_fault;

    assign w_req_nop = (bus_if.req_op == OP_NOP) || (bus_if.req_op == OP_RSVD);

    // Stack bounds are decided at accept time; SP cannot move until this op retires.
    always_comb begin
        w_req_fault = 1'b0;
        case (bus_if.req_op)
            OP_PUSH:   w_req_fault = (sp_q <  STACK_LIMIT);
            OP_PUSH32: w_req_fault = (sp_q <  (STACK_LIMIT + 32'd1));
            OP_POP:    w_req_fault = (sp_q >= SP_RESET);
            OP_POP32:  w_req_fault = (sp_q >  (SP_RESET - 32'd2));
            default:   w_req_fault = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fault_d     = fault_q;
        wlo_d       = wlo_q;
        rlo_d       = rlo_q;
        sp_d        = sp_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_cs_d    = 1'b0;
        mem_push_d  = mem_push_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.req_valid) begin
                    op_d    = bus_if.req_op;
                    fault_d = w_req_fault;
                    wlo_d   = bus_if.req_wdata[15:0];
                    if (w_req_nop) begin
                        rsp_valid_d = 1'b1;
                        rdata_d     = 32'h0;
                        err_d       = 1'b0;
                    end else begin
                        state_d     = S_ACC1;
                        mem_wdata_d = bus_if.req_wdata[15:0];
                        case (bus_if.req_op)
                            OP_LOAD: begin
                                mem_addr_d = bus_if.req_addr;
                                mem_read_d = 1'b1;
                            end
                            OP_STORE: begin
                                mem_addr_d  = bus_if.req_addr;
                                mem_write_d = 1'b1;
                            end
                            OP_PUSH: begin
                                mem_addr_d  = sp_q;
                                mem_write_d = 1'b1;
                            end
                            OP_POP: begin
                                mem_addr_d = sp_q + 32'd1;
                                mem_read_d = 1'b1;
                            end
                            OP_PUSH32: begin
                                mem_addr_d  = sp_q;
                                mem_wdata_d = bus_if.req_wdata[31:16];
                                mem_write_d = 1'b1;
                            end
                            OP_POP32: begin
                                mem_addr_d = sp_q + 32'd1;
                                mem_read_d = 1'b1;
                            end
                            default: ;
                        endcase
                        if (w_req_fault) begin
                            mem_read_d  = 1'b0;
                            mem_write_d = 1'b0;
                        end
                        mem_cs_d = ~w_req_fault;
                        if (mem_write_d) begin
                            mem_push_d = ~mem_push_q;
                        end
                    end
                end
            end

            S_ACC1: begin
                if ((op_q == OP_PUSH32) || (op_q == OP_POP32)) begin
                    state_d  = S_ACC2;
                    rlo_d    = bus_if.mem_read_data;
                    mem_cs_d = ~fault_q;
                    if (op_q == OP_PUSH32) begin
                        mem_addr_d  = sp_q - 32'd1;
                        mem_wdata_d = wlo_q;
                        mem_write_d = ~fault_q;
                        mem_push_d  = mem_push_q ^ ~fault_q;
                    end else begin
                        mem_addr_d = sp_q + 32'd2;
                        mem_read_d = ~fault_q;
                    end
                end else begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    err_d       = fault_q;
                    rdata_d     = 32'h0;
                    if (!fault_q) begin
                        if ((op_q == OP_LOAD) || (op_q == OP_POP)) begin
                            rdata_d = {16'h0, bus_if.mem_read_data};
                        end
                        if (op_q == OP_PUSH) begin
                            sp_d = sp_q - 32'd1;
                        end
                        if (op_q == OP_POP) begin
                            sp_d = sp_q + 32'd1;
                        end
                    end
                end
            end

            S_ACC2: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                err_d       = fault_q;
                rdata_d     = 32'h0;
                if (!fault_q) begin
                    if (op_q == OP_POP32) begin
                        rdata_d = {bus_if.mem_read_data, rlo_q};
                        sp_d    = sp_q + 32'd2;
                    end else begin
                        sp_d    = sp_q - 32'd2;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            fault_q     <= 1'b0;
            wlo_q       <= 16'h0;
            rlo_q       <= 16'h0;
            sp_q        <= SP_RESET;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 16'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_push_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            fault_q     <= fault_d;
            wlo_q       <= wlo_d;
            rlo_q       <= rlo_d;
            sp_q        <= sp_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_cs_q    <= mem_cs_d;
            mem_push_q  <= mem_push_d;
        end
    end

    assign bus_if.stall          = (state_q != S_IDLE) || (bus_if.req_valid && !w_req_nop);
    assign bus_if.rsp_valid      = rsp_valid_q;
    assign bus_if.rsp_rdata      = rdata_q;
    assign bus_if.err            = err_q;
    assign bus_if.sp             = sp_q;
    assign bus_if.mem_address    = mem_addr_q;
    assign bus_if.mem_write_data = mem_wdata_q;
    assign bus_if.mem_read       = mem_read_q;
    assign bus_if.mem_write      = mem_write_q;
    assign bus_if.mem_cs         = mem_cs_q;
    assign bus_if.mem_push       = mem_push_q;

endmodule

`default_nettype wire
